interrupt_ctrl: RTL and testbench

Multi-source interrupt controller for the RAT MCU. It sits between external interrupt lines and the control unit. It synchronizes and edge-detects each source, latches pending requests, applies a mask and the global I flag, and presents one prioritized request and vector to the control unit's interrupt cycle. It also owns the I flag and the C/Z shadow registers used by SEI/CLI/RETIE/RETID.

---
 rtl/rat_int_pkg.sv | 6 +
 rtl/irq_sync_edge.sv | 24 ++
 rtl/interrupt_ctrl.sv | 96 +++++++++
 tb/tb_interrupt_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/rat_int_pkg.sv
// Shared types and defaults for the RAT MCU interrupt controller.
package rat_int_pkg;
   typedef enum logic {ST_IDLE, ST_SERV} int_state_t;
   localparam int         N_SRC_DEF    = 4;
   localparam logic [9:0] VEC_BASE_DEF = 10'h3FC;
endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt source: 2-flop synchronizer, delay flop, rising-edge pulse.
module irq_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic irq,
   output logic rise
);
   logic sync1, sync2, sync3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= irq;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   // Flops reset low, so a line already high at reset release yields one edge.
   assign rise = sync2 & ~sync3;
endmodule

// File: rtl/interrupt_ctrl.sv
// Multi-source interrupt controller: pending latch, mask, lowest-index priority,
// single-level service FSM owning the I flag and C/Z shadow registers.
module interrupt_ctrl
   import rat_int_pkg::*;
#(
   parameter int         N_SRC    = N_SRC_DEF,
   parameter logic [9:0] VEC_BASE = VEC_BASE_DEF,
   localparam int        ID_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [N_SRC-1:0] IRQ,
   input  logic             MASK_WE,
   input  logic [N_SRC-1:0] MASK_IN,
   input  logic             I_SET,
   input  logic             I_CLR,
   input  logic             INT_ACK,
   input  logic             INT_RET,
   input  logic             RET_IE,
   input  logic             C_IN,
   input  logic             Z_IN,
   output logic             INT_REQ,
   output logic [ID_W-1:0]  INT_ID,
   output logic [9:0]       INT_VEC,
   output logic             I_FLAG,
   output logic             SHAD_C,
   output logic             SHAD_Z,
   output logic [N_SRC-1:0] PENDING,
   output logic             IN_SERVICE
);
   int_state_t       state;
   logic [N_SRC-1:0] rise, mask, req_vec, clr;
   logic [ID_W-1:0]  win_id, id_q;
   logic             ack, ret;

   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      irq_sync_edge u_sync (.clk(CLK), .rst_n(RESET_N), .irq(IRQ[i]), .rise(rise[i]));
   end

   assign req_vec = PENDING & mask;

   always_comb begin
      win_id = '0;
      for (int i = N_SRC - 1; i >= 0; i--)
         if (req_vec[i]) win_id = ID_W'(i);
   end

   assign INT_REQ    = (state == ST_IDLE) & I_FLAG & (|req_vec);
   assign ack        = INT_ACK & INT_REQ;
   assign ret        = INT_RET & (state == ST_SERV);
   assign IN_SERVICE = (state == ST_SERV);
   assign INT_ID     = (state == ST_SERV) ? id_q : win_id;
   assign INT_VEC    = VEC_BASE + 10'(INT_ID);

   always_comb begin
      clr = '0;
      if (ack) clr[win_id] = 1'b1;
   end

   // A new edge outranks the acknowledge clear of the same bit.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         PENDING <= '0;
         mask    <= '0;
      end else begin
         PENDING <= (PENDING & ~clr) | rise;
         if (MASK_WE) mask <= MASK_IN;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state  <= ST_IDLE;
         id_q   <= '0;
         I_FLAG <= 1'b0;
         SHAD_C <= 1'b0;
         SHAD_Z <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (ack) begin
               state  <= ST_SERV;
               id_q   <= win_id;
               SHAD_C <= C_IN;
               SHAD_Z <= Z_IN;
            end
            ST_SERV: if (INT_RET) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
         // FSM transitions own I_FLAG; otherwise CLI beats SEI.
         if (ack)        I_FLAG <= 1'b0;
         else if (ret)   I_FLAG <= RET_IE;
         else if (I_CLR) I_FLAG <= 1'b0;
         else if (I_SET) I_FLAG <= 1'b1;
      end
   end
endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl with hand-computed expectations.
module tb_interrupt_ctrl;
   logic       CLK = 1'b0;
   logic       RESET_N, MASK_WE, I_SET, I_CLR, INT_ACK, INT_RET, RET_IE, C_IN, Z_IN;
   logic [3:0] IRQ, MASK_IN, PENDING;
   logic       INT_REQ, I_FLAG, SHAD_C, SHAD_Z, IN_SERVICE;
   logic [1:0] INT_ID;
   logic [9:0] INT_VEC;
   int         n_chk = 0, n_err = 0;

   interrupt_ctrl dut (
      .CLK(CLK), .RESET_N(RESET_N), .IRQ(IRQ), .MASK_WE(MASK_WE), .MASK_IN(MASK_IN),
      .I_SET(I_SET), .I_CLR(I_CLR), .INT_ACK(INT_ACK), .INT_RET(INT_RET), .RET_IE(RET_IE),
      .C_IN(C_IN), .Z_IN(Z_IN), .INT_REQ(INT_REQ), .INT_ID(INT_ID), .INT_VEC(INT_VEC),
      .I_FLAG(I_FLAG), .SHAD_C(SHAD_C), .SHAD_Z(SHAD_Z), .PENDING(PENDING),
      .IN_SERVICE(IN_SERVICE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      RESET_N = 0; IRQ = 0; MASK_WE = 0; MASK_IN = 0; I_SET = 0; I_CLR = 0;
      INT_ACK = 0; INT_RET = 0; RET_IE = 0; C_IN = 0; Z_IN = 0;
      #23;
      chk("rst_req", INT_REQ, 0);
      chk("rst_vec", INT_VEC, 10'h3FC);
      chk("rst_pend", PENDING, 0);
      chk("rst_iflag", I_FLAG, 0);
      chk("rst_serv", IN_SERVICE, 0);
      tick(); RESET_N = 1;

      // idle with all lines low
      MASK_WE = 1; MASK_IN = 4'b1111; I_SET = 1; tick();
      MASK_WE = 0; I_SET = 0; tick(5);
      chk("idle_req", INT_REQ, 0);
      chk("idle_pend", PENDING, 0);
      chk("idle_vec", INT_VEC, 10'h3FC);
      chk("idle_iflag", I_FLAG, 1);

      // source 2 pulse, latency k+2
      MASK_WE = 1; MASK_IN = 4'b0100; tick(); MASK_WE = 0;
      IRQ[2] = 1; tick();
      tick(); IRQ[2] = 0;
      chk("lat_k1_pend", PENDING, 0);
      chk("lat_k1_req", INT_REQ, 0);
      tick();
      chk("s2_pend", PENDING, 4'b0100);
      chk("s2_req", INT_REQ, 1);
      chk("s2_id", INT_ID, 2);
      chk("s2_vec", INT_VEC, 10'h3FE);
      INT_ACK = 1; tick(); INT_ACK = 0;
      chk("s2_ack_pend", PENDING, 0);
      INT_RET = 1; RET_IE = 1; tick(); INT_RET = 0;
      chk("s2_ret_iflag", I_FLAG, 1);

      // sources 1 and 3, acknowledge source 1
      MASK_WE = 1; MASK_IN = 4'b1111; tick(); MASK_WE = 0;
      IRQ = 4'b1010; tick(3); IRQ = 0;
      chk("p13_pend", PENDING, 4'b1010);
      chk("p13_id", INT_ID, 1);
      C_IN = 1; Z_IN = 0; INT_ACK = 1; tick(); INT_ACK = 0; C_IN = 0;
      chk("ack1_id", INT_ID, 1);
      chk("ack1_pend", PENDING, 4'b1000);
      chk("ack1_iflag", I_FLAG, 0);
      chk("ack1_shc", SHAD_C, 1);
      chk("ack1_shz", SHAD_Z, 0);
      chk("ack1_serv", IN_SERVICE, 1);
      chk("ack1_req", INT_REQ, 0);
      tick();
      chk("ack1_hold_id", INT_ID, 1);

      // RETIE with source 3 pending
      INT_RET = 1; RET_IE = 1; tick(); INT_RET = 0;
      chk("retie_serv", IN_SERVICE, 0);
      chk("retie_iflag", I_FLAG, 1);
      chk("retie_req", INT_REQ, 1);
      chk("retie_id", INT_ID, 3);
      chk("retie_vec", INT_VEC, 10'h3FF);
      Z_IN = 1; INT_ACK = 1; tick(); INT_ACK = 0; Z_IN = 0;
      chk("ack3_shc", SHAD_C, 0);
      chk("ack3_shz", SHAD_Z, 1);
      chk("ack3_pend", PENDING, 0);
      IRQ[0] = 1; tick(3); IRQ[0] = 0;
      chk("nest_pend", PENDING, 4'b0001);
      chk("nest_req", INT_REQ, 0);
      INT_RET = 1; RET_IE = 0; tick(); INT_RET = 0;
      chk("retid_iflag", I_FLAG, 0);
      chk("retid_req", INT_REQ, 0);
      chk("retid_serv", IN_SERVICE, 0);
      INT_RET = 1; RET_IE = 1; tick(); INT_RET = 0;
      chk("ret_idle_ign", I_FLAG, 0);
      I_SET = 1; tick(); I_SET = 0;
      chk("sei_req", INT_REQ, 1);
      chk("sei_id", INT_ID, 0);
      INT_ACK = 1; tick(); INT_ACK = 0;
      INT_RET = 1; RET_IE = 1; tick(); INT_RET = 0;
      INT_ACK = 1; tick(); INT_ACK = 0;
      chk("ack_noreq", IN_SERVICE, 0);

      // masked source 0, then unmask; mask write during acknowledge
      MASK_WE = 1; MASK_IN = 4'b0000; tick(); MASK_WE = 0;
      IRQ[0] = 1; tick(3); IRQ[0] = 0;
      chk("msk_pend", PENDING, 4'b0001);
      chk("msk_req", INT_REQ, 0);
      MASK_WE = 1; MASK_IN = 4'b0001; tick(); MASK_WE = 0;
      chk("unmsk_req", INT_REQ, 1);
      MASK_WE = 1; MASK_IN = 4'b0000; INT_ACK = 1; tick(); MASK_WE = 0; INT_ACK = 0;
      chk("ackmw_serv", IN_SERVICE, 1);
      chk("ackmw_id", INT_ID, 0);
      chk("ackmw_pend", PENDING, 0);
      INT_RET = 1; RET_IE = 1; tick(); INT_RET = 0;

      // edge on source 1 coincides with its acknowledge
      MASK_WE = 1; MASK_IN = 4'b1111; tick(); MASK_WE = 0;
      IRQ[1] = 1; tick(3); IRQ[1] = 0; tick(3);
      chk("coll_pre_pend", PENDING, 4'b0010);
      IRQ[1] = 1; tick(2);
      INT_ACK = 1; tick(); INT_ACK = 0; IRQ[1] = 0;
      chk("coll_serv", IN_SERVICE, 1);
      chk("coll_id", INT_ID, 1);
      chk("coll_pend", PENDING, 4'b0010);
      I_SET = 1; tick();
      chk("sei_serv", I_FLAG, 1);
      I_CLR = 1; tick(); I_SET = 0; I_CLR = 0;
      chk("sei_cli", I_FLAG, 0);
      I_SET = 1; INT_RET = 1; RET_IE = 0; tick(); I_SET = 0; INT_RET = 0;
      chk("ret_over_sei", I_FLAG, 0);

      // reset mid-service with a source held high through release
      I_SET = 1; tick(); I_SET = 0;
      INT_ACK = 1; tick(); INT_ACK = 0;
      chk("rs_serv", IN_SERVICE, 1);
      IRQ[2] = 1; tick(3);
      chk("rs_pend", PENDING, 4'b0100);
      #2 RESET_N = 0; #3;
      chk("rs2_serv", IN_SERVICE, 0);
      chk("rs2_pend", PENDING, 0);
      chk("rs2_vec", INT_VEC, 10'h3FC);
      chk("rs2_shz", SHAD_Z, 0);
      tick(2); RESET_N = 1;
      tick(2);
      chk("rel_k1_pend", PENDING, 0);
      tick();
      chk("rel_pend", PENDING, 4'b0100);
      chk("rel_req", INT_REQ, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
